fc_phase_calibrator: RTL and testbench
======================================

// Module: fc_phase_calibrator
// PURPOSE
//  Sequencer for the fast-command phase adjuster's delay enables (clkDelayEn, fcDelayEn).
//  Sweeps all four enable combinations while the fast-command stream carries IDLE.
//  Counts IDLE-pattern mismatches on the deserialized words for each setting.
//  Selects the lowest-error setting and holds it on its outputs.
//  Sits between the fast-command word aligner (word input) and the phase adjuster (enable outputs).
// PARAMETERS
//  IDLE_PATTERN  8'hF0  expected fast-command IDLE word
//  N_WORDS       256    valid words observed per setting
//  SETTLE_CYC    16     clk320 cycles waited after each enable change, before counting
//  CNT_W         9      error counter width; counters saturate at 2^CNT_W-1
//  MAX_ERR       2      best error count above this value sets fail
// PORTS
//  clk320       in   1      320 MHz bit clock; the only clock
//  rst          in   1      synchronous reset, active-high
//  start        in   1      one-cycle pulse; requests a sweep
//  wordIn       in   8      deserialized fast-command word
//  wordValid    in   1      wordIn qualifier (nominally 1 per 8 cycles)
//  clkDelayEn   out  1      to phase adjuster; equals sel[1]
//  fcDelayEn    out  1      to phase adjuster; equals sel[0]
//  busy         out  1      sweep in progress
//  done         out  1      result valid, held until the next sweep or rst
//  fail         out  1      bestErr > MAX_ERR (valid when done=1)
//  bestSel      out  2      chosen setting {clkDelayEn,fcDelayEn}
//  bestErr      out  CNT_W  error count of the chosen setting
// BEHAVIOUR
//  - Reset: every output is 0; FSM goes to IDLE; sel=0; all counters cleared.
//  - FSM states: IDLE -> SETTLE -> COUNT -> (SETTLE for next sel | APPLY) -> DONE.
//  - IDLE/DONE: start=1 -> SETTLE on the next edge, with sel=0.
//    * In that same next cycle: busy=1, done=0, fail=0.
//  - start while busy is ignored.
//  - During the sweep, the enable outputs follow sel; they are registered and change on SETTLE entry.
//  - SETTLE: counts SETTLE_CYC cycles, ignoring wordValid, then enters COUNT with the error counter cleared.
//  - COUNT:
//    * Each wordValid=1 increments the word counter.
//    * If wordIn != IDLE_PATTERN, the error counter also increments, saturating at 2^CNT_W-1.
//    * On the N_WORDS-th valid word (that word included), compare and advance.
//  - Compare: if sel==0 or err < bestErr (strict), then bestSel<=sel and bestErr<=err.
//    * Ties resolve to the lowest sel.
//  - Advance: sel<3 -> sel+1, SETTLE.
//  - APPLY after sel=3 (one cycle):
//    * Enables take bestSel.
//    * fail <= (bestErr > MAX_ERR).
//    * Next cycle: DONE, busy=0, done=1.
//  - Sweep order: sel 0 = none, 1 = fc delayed, 2 = clk delayed, 3 = both.
//  - On fail=1, bestSel is still applied (best-effort).
//  - Latency with continuous wordValid: 4*(SETTLE_CYC+N_WORDS)+2 cycles from start to done.
//  - rst mid-sweep: reset values on the next edge, enables back to 0, partial results discarded.
//  - rst and start in the same cycle: rst wins.
//  - wordValid is ignored outside COUNT, except as defined under CONFIGURATION.
// CONFIGURATION
//  PHASE_CAL_RECAL_EN defined: DONE keeps monitoring in windows of N_WORDS valid words.
//    * Window error count > MAX_ERR -> done=0, busy=1, sweep restarts at sel=0 on the next edge.
//    * If fail=1 already, auto-restart is suppressed; start is required.
//  PHASE_CAL_RECAL_EN undefined: DONE holds until start or rst; no monitoring logic is built.
// TESTING
//  1 Clean stream, default params:
//    * wordIn=F0 always, wordValid every cycle, start pulse.
//    * Expect done after 1090 cycles, bestSel=0, bestErr=0, fail=0, enables 0/0.
//  2 Inject errors per setting: 10 (sel0), 0 (sel1), 5 (sel2), 0 (sel3).
//    * Expect bestSel=1 (tie -> lowest), fcDelayEn=1, clkDelayEn=0, fail=0.
//  3 50 bad words in every setting -> bestSel=0, bestErr=50, fail=1, done=1.
//  4 CNT_W=4, all words 8'h00 -> bestErr=15 (saturated), fail=1.
//  5 Assert rst mid-COUNT of sel=2 -> next cycle all outputs 0.
//    * A start pulse during busy in a separate run changes nothing.
//  6 With PHASE_CAL_RECAL_EN:
//    * After a clean done, 3 bad words in one window -> busy=1 next edge, new sweep, done again.
//    * Without the macro: done stays 1.

Source files
------------

// File: rtl/fc_phase_calibrator.sv
// Sweeps the four {clkDelayEn,fcDelayEn} settings on an IDLE fast-command stream and holds the lowest-error one.
// Optional PHASE_CAL_RECAL_EN: keep monitoring in DONE and re-sweep when a window exceeds MAX_ERR.
module fc_phase_calibrator #(
  parameter logic [7:0]  IDLE_PATTERN = 8'hF0,
  parameter int unsigned N_WORDS      = 256,
  parameter int unsigned SETTLE_CYC   = 16,
  parameter int unsigned CNT_W        = 9,
  parameter int unsigned MAX_ERR      = 2
) (
  input  logic             clk320,
  input  logic             rst,
  input  logic             start,
  input  logic [7:0]       wordIn,
  input  logic             wordValid,
  output logic             clkDelayEn,
  output logic             fcDelayEn,
  output logic             busy,
  output logic             done,
  output logic             fail,
  output logic [1:0]       bestSel,
  output logic [CNT_W-1:0] bestErr
);

  localparam int unsigned      SW          = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam int unsigned      WW          = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;
  localparam logic [SW-1:0]    SETTLE_LAST = SW'(SETTLE_CYC - 1);
  localparam logic [WW-1:0]    WORD_LAST   = WW'(N_WORDS - 1);
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_COUNT,
    S_APPLY,
    S_DONE
  } state_t;

  state_t           stateQ, stateD;
  logic [1:0]       selQ, selD;
  logic [1:0]       enQ, enD;
  logic [SW-1:0]    settleQ, settleD;
  logic [WW-1:0]    wordCntQ, wordCntD;
  logic [CNT_W-1:0] errQ, errD;
  logic [1:0]       bestSelQ, bestSelD;
  logic [CNT_W-1:0] bestErrQ, bestErrD;
  logic             busyQ, busyD;
  logic             doneQ, doneD;
  logic             failQ, failD;
`ifdef PHASE_CAL_RECAL_EN
  logic [WW-1:0]    winCntQ, winCntD;
  logic [CNT_W-1:0] winErrQ, winErrD;
  logic [CNT_W-1:0] winErrFinal;
`endif

  logic             badWord;
  logic             launch;
  logic [CNT_W-1:0] errFinal;

  function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  assign badWord = (wordIn != IDLE_PATTERN);

  always_ff @(posedge clk320) begin
    if (rst) begin
      stateQ   <= S_IDLE;
      selQ     <= '0;
      enQ      <= '0;
      settleQ  <= '0;
      wordCntQ <= '0;
      errQ     <= '0;
      bestSelQ <= '0;
      bestErrQ <= '0;
      busyQ    <= 1'b0;
      doneQ    <= 1'b0;
      failQ    <= 1'b0;
`ifdef PHASE_CAL_RECAL_EN
      winCntQ  <= '0;
      winErrQ  <= '0;
`endif
    end else begin
      stateQ   <= stateD;
      selQ     <= selD;
      enQ      <= enD;
      settleQ  <= settleD;
      wordCntQ <= wordCntD;
      errQ     <= errD;
      bestSelQ <= bestSelD;
      bestErrQ <= bestErrD;
      busyQ    <= busyD;
      doneQ    <= doneD;
      failQ    <= failD;
`ifdef PHASE_CAL_RECAL_EN
      winCntQ  <= winCntD;
      winErrQ  <= winErrD;
`endif
    end
  end

  always_comb begin
    stateD   = stateQ;
    selD     = selQ;
    enD      = enQ;
    settleD  = settleQ;
    wordCntD = wordCntQ;
    errD     = errQ;
    bestSelD = bestSelQ;
    bestErrD = bestErrQ;
    busyD    = busyQ;
    doneD    = doneQ;
    failD    = failQ;
    launch   = 1'b0;
    errFinal = errQ;
`ifdef PHASE_CAL_RECAL_EN
    winCntD     = winCntQ;
    winErrD     = winErrQ;
    winErrFinal = winErrQ;
`endif

    case (stateQ)
      S_IDLE: launch = start;

      S_SETTLE: begin
        if (settleQ == SETTLE_LAST) begin
          stateD   = S_COUNT;
          errD     = '0;
          wordCntD = '0;
        end else begin
          settleD = settleQ + SW'(1);
        end
      end

      S_COUNT: begin
        if (wordValid) begin
          errFinal = badWord ? satInc(errQ) : errQ;
          errD     = errFinal;
          wordCntD = wordCntQ + WW'(1);
          if (wordCntQ == WORD_LAST) begin
            // Strict less-than keeps the lowest sel on ties; sel 0 always seeds the best.
            if ((selQ == 2'd0) || (errFinal < bestErrQ)) begin
              bestSelD = selQ;
              bestErrD = errFinal;
            end
            if (selQ == 2'd3) begin
              stateD = S_APPLY;
            end else begin
              selD    = selQ + 2'd1;
              enD     = selQ + 2'd1;
              settleD = '0;
              stateD  = S_SETTLE;
            end
          end
        end
      end

      S_APPLY: begin
        enD    = bestSelQ;
        failD  = (32'(bestErrQ) > MAX_ERR);
        busyD  = 1'b0;
        doneD  = 1'b1;
        stateD = S_DONE;
`ifdef PHASE_CAL_RECAL_EN
        winCntD = '0;
        winErrD = '0;
`endif
      end

      S_DONE: begin
        if (start) begin
          launch = 1'b1;
        end
`ifdef PHASE_CAL_RECAL_EN
        else if (wordValid) begin
          winErrFinal = badWord ? satInc(winErrQ) : winErrQ;
          winErrD     = winErrFinal;
          winCntD     = winCntQ + WW'(1);
          if (winCntQ == WORD_LAST) begin
            winCntD = '0;
            winErrD = '0;
            // A failed calibration never retriggers itself; only start re-runs it.
            if ((32'(winErrFinal) > MAX_ERR) && !failQ) begin
              launch = 1'b1;
            end
          end
        end
`endif
      end

      default: stateD = S_IDLE;
    endcase

    if (launch) begin
      stateD  = S_SETTLE;
      selD    = '0;
      enD     = '0;
      settleD = '0;
      busyD   = 1'b1;
      doneD   = 1'b0;
      failD   = 1'b0;
    end
  end

  assign clkDelayEn = enQ[1];
  assign fcDelayEn  = enQ[0];
  assign busy       = busyQ;
  assign done       = doneQ;
  assign fail       = failQ;
  assign bestSel    = bestSelQ;
  assign bestErr    = bestErrQ;

endmodule

// File: tb/tb_fc_phase_calibrator.sv
// Self-checking bench for fc_phase_calibrator: vector table, randomized sweeps against an argmin model,
// plus reset, start-while-busy and DONE-monitoring sequences. A second instance uses CNT_W=4 for saturation.
module tb_fc_phase_calibrator;

  localparam int SETTLE = 16;
  localparam int NW     = 256;

  logic       clk320 = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] wordIn;
  logic       wordValid;

  logic       clkDelayEn, fcDelayEn, busy, done, fail;
  logic [1:0] bestSel;
  logic [8:0] bestErr;

  logic       clkDelayEn4, fcDelayEn4, busy4, done4, fail4;
  logic [1:0] bestSel4;
  logic [3:0] bestErr4;

  fc_phase_calibrator dut (
    .clk320(clk320), .rst(rst), .start(start), .wordIn(wordIn), .wordValid(wordValid),
    .clkDelayEn(clkDelayEn), .fcDelayEn(fcDelayEn), .busy(busy), .done(done), .fail(fail),
    .bestSel(bestSel), .bestErr(bestErr)
  );

  fc_phase_calibrator #(.CNT_W(4)) dut4 (
    .clk320(clk320), .rst(rst), .start(start), .wordIn(wordIn), .wordValid(wordValid),
    .clkDelayEn(clkDelayEn4), .fcDelayEn(fcDelayEn4), .busy(busy4), .done(done4), .fail(fail4),
    .bestSel(bestSel4), .bestErr(bestErr4)
  );

  always #5 clk320 = ~clk320;

  typedef logic [3:0][8:0] quad_t;
  typedef struct {
    quad_t nbad;
    bit    midStart;
    int    expSel;
    int    expErr;
    bit    expFail;
  } vec_t;

  int    errors = 0;
  int    checks = 0;
  int    curBad[4];
  vec_t  vecs[7];

  function automatic quad_t q4(input int b0, input int b1, input int b2, input int b3);
    quad_t q;
    q[0] = 9'(b0);
    q[1] = 9'(b1);
    q[2] = 9'(b2);
    q[3] = 9'(b3);
    return q;
  endfunction

  function automatic logic [7:0] badValue();
    logic [7:0] v;
    v = 8'($urandom);
    if (v == 8'hF0) v = 8'h0F;
    return v;
  endfunction

  // Reference: per-setting error = bad words capped at counter max; pick the first minimum.
  task automatic refModel(input int cap, output int sel, output int err);
    int e[4];
    for (int s = 0; s < 4; s++) e[s] = (curBad[s] > cap) ? cap : curBad[s];
    sel = 0;
    err = e[0];
    for (int s = 1; s < 4; s++) begin
      if (e[s] < err) begin
        sel = s;
        err = e[s];
      end
    end
  endtask

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk320);
    #1;
  endtask

  // Runs one full sweep; bad word counts per setting come from curBad.
  task automatic applyStimulus(input bit gaps, input bit midStart,
                               input int expSel, input int expErr, input bit expFail);
    int edges;
    int counted;
    int badLeft;
    int sel4, err4;
    bit v;
    refModel(15, sel4, err4);
    edges     = 0;
    wordValid = 1'b0;
    start     = 1'b1;
    tick();
    edges++;
    start = 1'b0;
    checkOutput("launchBusy", int'(busy), 1);
    checkOutput("launchDoneFail", int'({done, fail}), 0);
    for (int s = 0; s < 4; s++) begin
      for (int i = 0; i < SETTLE; i++) begin
        wordValid = 1'($urandom);
        wordIn    = badValue();
        start     = midStart && (s == 1) && (i == 3);
        tick();
        edges++;
        if (i == 5) checkOutput($sformatf("settleEnables%0d", s), int'({clkDelayEn, fcDelayEn}), s);
      end
      start   = 1'b0;
      counted = 0;
      badLeft = curBad[s];
      while (counted < NW) begin
        v         = gaps ? ($urandom_range(3) != 0) : 1'b1;
        wordValid = v;
        start     = midStart && (s == 2) && (counted == 100);
        if (v) begin
          if (int'($urandom_range(NW - 1 - counted)) < badLeft) begin
            wordIn = badValue();
            badLeft--;
          end else begin
            wordIn = 8'hF0;
          end
        end else begin
          wordIn = badValue();
        end
        tick();
        edges++;
        if (v) counted++;
      end
      start = 1'b0;
    end
    wordValid = 1'b0;
    checkOutput("doneBeforeApply", int'(done), 0);
    tick();
    edges++;
    if (!gaps) checkOutput("latency", edges, 4 * (SETTLE + NW) + 2);
    checkOutput("done", int'(done), 1);
    checkOutput("busyCleared", int'(busy), 0);
    checkOutput("bestSel", int'(bestSel), expSel);
    checkOutput("bestErr", int'(bestErr), expErr);
    checkOutput("fail", int'(fail), int'(expFail));
    checkOutput("enables", int'({clkDelayEn, fcDelayEn}), expSel);
    checkOutput("bestErrSat4", int'(bestErr4), err4);
    checkOutput("bestSel4", int'(bestSel4), sel4);
    checkOutput("fail4", int'(fail4), int'(err4 > 2));
  endtask

  initial begin
    int rs, re;
    vecs[0] = '{q4(0, 0, 0, 0),         1'b0, 0, 0,   1'b0};
    vecs[1] = '{q4(10, 0, 5, 0),        1'b0, 1, 0,   1'b0};
    vecs[2] = '{q4(50, 50, 50, 50),     1'b0, 0, 50,  1'b1};
    vecs[3] = '{q4(256, 256, 256, 256), 1'b0, 0, 256, 1'b1};
    vecs[4] = '{q4(3, 2, 2, 1),         1'b1, 3, 1,   1'b0};
    vecs[5] = '{q4(2, 2, 7, 2),         1'b0, 0, 2,   1'b0};
    vecs[6] = '{q4(9, 3, 4, 3),         1'b0, 1, 3,   1'b1};

    rst       = 1'b1;
    start     = 1'b0;
    wordIn    = 8'hF0;
    wordValid = 1'b0;
    repeat (3) tick();
    checkOutput("resetOutputs", int'({clkDelayEn, fcDelayEn, busy, done, fail, bestSel, bestErr}), 0);
    checkOutput("resetOutputs4", int'({clkDelayEn4, fcDelayEn4, busy4, done4, fail4, bestSel4, bestErr4}), 0);
    rst = 1'b0;
    tick();

    for (int k = 0; k < 7; k++) begin
      for (int s = 0; s < 4; s++) curBad[s] = int'(vecs[k].nbad[s]);
      $display("[TB] vector %0d", k);
      applyStimulus(1'b0, vecs[k].midStart, vecs[k].expSel, vecs[k].expErr, vecs[k].expFail);
    end

    for (int r = 0; r < 5; r++) begin
      for (int s = 0; s < 4; s++)
        curBad[s] = ($urandom_range(3) == 0) ? int'($urandom_range(256)) : int'($urandom_range(5));
      refModel(511, rs, re);
      $display("[TB] random sweep %0d: bad %0d %0d %0d %0d", r, curBad[0], curBad[1], curBad[2], curBad[3]);
      applyStimulus(1'b1, 1'b0, rs, re, re > 2);
    end

    // Reset in the middle of counting sel=2.
    start = 1'b1;
    tick();
    start     = 1'b0;
    wordValid = 1'b1;
    wordIn    = 8'h00;
    repeat (2 * (SETTLE + NW) + SETTLE + 40) tick();
    checkOutput("midEnables", int'({clkDelayEn, fcDelayEn}), 2);
    checkOutput("midBusy", int'(busy), 1);
    rst = 1'b1;
    tick();
    checkOutput("midReset", int'({clkDelayEn, fcDelayEn, busy, done, fail, bestSel, bestErr}), 0);
    rst       = 1'b0;
    wordValid = 1'b0;
    repeat (3) tick();
    checkOutput("idleAfterReset", int'({busy, done}), 0);

    // rst and start together: reset wins.
    for (int s = 0; s < 4; s++) curBad[s] = 0;
    applyStimulus(1'b0, 1'b0, 0, 0, 1'b0);
    rst   = 1'b1;
    start = 1'b1;
    tick();
    checkOutput("rstStart", int'({clkDelayEn, fcDelayEn, busy, done, fail, bestSel, bestErr}), 0);
    rst   = 1'b0;
    start = 1'b0;
    tick();
    checkOutput("rstStartNoSweep", int'(busy), 0);

    // Degraded stream after a clean result.
    curBad[0] = 0; curBad[1] = 2; curBad[2] = 0; curBad[3] = 0;
    applyStimulus(1'b0, 1'b0, 0, 0, 1'b0);
    wordValid = 1'b1;
    for (int w = 0; w < NW; w++) begin
      wordIn = (w == 10 || w == 20 || w == 30) ? 8'h55 : 8'hF0;
      tick();
    end
    wordValid = 1'b0;
`ifdef PHASE_CAL_RECAL_EN
    checkOutput("recalBusy", int'(busy), 1);
    checkOutput("recalDone", int'(done), 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
`else
    checkOutput("holdDone", int'(done), 1);
    checkOutput("holdBusy", int'(busy), 0);
    repeat (20) tick();
    checkOutput("holdEnables", int'({clkDelayEn, fcDelayEn}), 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
